// File: rtl/spi_slave.sv
// SPI mode-0 responder (CPOL=0, CPHA=0, MSB first).
// sclk/cs/mosi are asynchronous and oversampled through synchronizers.
// Received frames appear on rx_data with a one-cycle rx_valid pulse.
// miso is driven from a tx shift register fed by a one-deep host buffer.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   tx_data/valid     host write port, accepted when tx_valid & tx_ready
//   tx_ready          transmit buffer empty
//   rx_data/rx_valid  last complete frame and its update pulse
//   busy, miso_oe     frame active (synchronized cs low, frame accepted)
//   frame_err         pulse: cs rose with a partial frame
//   tx_underrun       pulse: IDLE_FILL loaded because the buffer was empty
//   sclk, cs, mosi    SPI inputs from the master
//   miso              SPI data output
module spi_slave #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL = DATA_WIDTH'(8'hFF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  tx_underrun,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe
);

  localparam int unsigned CNT_W   = $clog2(DATA_WIDTH + 1);
  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
  logic                    sclk_q, cs_q;
  logic [FLUSH_W-1:0]      flush_cnt;
  logic                    armed;
  logic [DATA_WIDTH-1:0]   tx_buf;
  logic [DATA_WIDTH-1:0]   tx_shift;
  logic [DATA_WIDTH-1:0]   rx_shift;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    reload;

  logic sclk_s, cs_s, mosi_s;
  logic cs_fall_c, cs_rise_c, sclk_rise_c, sclk_fall_c;
  logic load_c;

  // Edge detection on the synchronized inputs, plus the shared load point.
  always_comb begin
    sclk_s      = sclk_sync[SYNC_STAGES-1];
    cs_s        = cs_sync[SYNC_STAGES-1];
    mosi_s      = mosi_sync[SYNC_STAGES-1];
    cs_fall_c   = cs_q & ~cs_s;
    cs_rise_c   = ~cs_q & cs_s;
    sclk_rise_c = ~sclk_q & sclk_s;
    sclk_fall_c = sclk_q & ~sclk_s;
    load_c      = 1'b0;
    if (state == IDLE)
      load_c = armed & cs_fall_c;
    else
      load_c = ~cs_rise_c & sclk_fall_c & reload;
  end

  // Synchronizers, transmit buffer and frame FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sclk_sync   <= '0;
      cs_sync     <= '1;
      mosi_sync   <= '0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      flush_cnt   <= '0;
      armed       <= 1'b0;
      tx_buf      <= '0;
      tx_ready    <= 1'b1;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      bit_cnt     <= '0;
      reload      <= 1'b0;
      busy        <= 1'b0;
      miso_oe     <= 1'b0;
      miso        <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;

      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;

      // Arm only once the chain holds real samples and cs is seen high, so a
      // frame that was already running across reset is ignored.
      if (flush_cnt != FLUSH_DONE)
        flush_cnt <= flush_cnt + FLUSH_W'(1);
      else if (cs_s)
        armed <= 1'b1;

      // Load point: take the pending byte, or IDLE_FILL if none.
      if (load_c) begin
        if (!tx_ready) begin
          tx_shift <= tx_buf;
          miso     <= tx_buf[DATA_WIDTH-1];
        end else begin
          tx_shift    <= IDLE_FILL;
          miso        <= IDLE_FILL[DATA_WIDTH-1];
          tx_underrun <= 1'b1;
        end
        tx_ready <= 1'b1;
      end

      // Host write sees the pre-load tx_ready; no bypass into the shifter.
      if (tx_valid && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (armed && cs_fall_c) begin
            state   <= ACTIVE;
            busy    <= 1'b1;
            miso_oe <= 1'b1;
            bit_cnt <= '0;
            reload  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise_c) begin
            state   <= IDLE;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
            miso    <= 1'b0;
            if (bit_cnt != '0)
              frame_err <= 1'b1;
            bit_cnt <= '0;
            reload  <= 1'b0;
          end else if (sclk_rise_c) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              reload   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (sclk_fall_c) begin
            if (reload) begin
              reload <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
              miso     <= tx_shift[DATA_WIDTH-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model at clk/8 drives the
// link, and pulse counters track rx_valid, frame_err and tx_underrun.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       tx_underrun;
  logic       sclk, cs, mosi;
  logic       miso, miso_oe;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int fe_cnt = 0;
  int ur_cnt = 0;
  logic [15:0] rx_hist = '0;

  spi_slave dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .frame_err(frame_err), .tx_underrun(tx_underrun), .sclk(sclk), .cs(cs),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  // Pulse counters and a history of the last two received bytes.
  always @(posedge clk) begin
    if (rx_valid) begin
      rx_cnt  <= rx_cnt + 1;
      rx_hist <= {rx_hist[7:0], rx_data};
    end
    if (frame_err)   fe_cnt <= fe_cnt + 1;
    if (tx_underrun) ur_cnt <= ur_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    cs = 1'b0;
    wait_clk(8);
  endtask

  // Shift n bits MSB-first; leaves sclk high after the last rise.
  task automatic xfer(input logic [15:0] tx, input int n, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      mosi = tx[n-1-i];
      wait_clk(4);
      sclk = 1'b1;
      rx   = {rx[14:0], miso};
      wait_clk(4);
    end
  endtask

  // cs rises while sclk is still high, so no trailing fall reaches the frame.
  task automatic end_frame();
    cs = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
    wait_clk(6);
  endtask

  task automatic test_reset();
    reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(1);
    checks++;
    if ({miso, miso_oe, busy, rx_valid, frame_err, tx_underrun} !== 6'b0) begin
      errors++; $display("FAIL reset_outs: got %b expected 000000",
        {miso, miso_oe, busy, rx_valid, frame_err, tx_underrun});
    end
    checks++;
    if (rx_data !== 8'h00 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_rx_ready: got rx_data=%h tx_ready=%b expected 00/1",
        rx_data, tx_ready);
    end
    wait_clk(6);
  endtask

  task automatic test_basic();
    logic [15:0] m;
    int r0, f0, u0;
    r0 = rx_cnt; f0 = fe_cnt; u0 = ur_cnt;
    host_write(8'h3C);
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL basic_preload_ready: got %b expected 0", tx_ready);
    end
    cs = 1'b0;
    wait_clk(1);
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready_early: got %b expected 0", tx_ready);
    end
    wait_clk(3);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b1 || miso_oe !== 1'b1) begin
      errors++; $display("FAIL basic_after_load: got ready=%b busy=%b oe=%b expected 1/1/1",
        tx_ready, busy, miso_oe);
    end
    wait_clk(4);
    xfer(16'h00A5, 8, m);
    end_frame();
    checks++;
    if (m[7:0] !== 8'h3C) begin
      errors++; $display("FAIL basic_miso: got %h expected 3c", m[7:0]);
    end
    checks++;
    if (rx_data !== 8'hA5 || rx_cnt - r0 != 1) begin
      errors++; $display("FAIL basic_rx: got %h pulses=%0d expected a5 pulses=1",
        rx_data, rx_cnt - r0);
    end
    checks++;
    if (fe_cnt != f0 || ur_cnt != u0) begin
      errors++; $display("FAIL basic_flags: got fe=%0d ur=%0d expected 0/0",
        fe_cnt - f0, ur_cnt - u0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] m;
    int r0, u0;
    r0 = rx_cnt; u0 = ur_cnt;
    host_write(8'h12);
    cs_low();
    host_write(8'h34);
    xfer(16'hA55A, 16, m);
    end_frame();
    checks++;
    if (rx_cnt - r0 != 2 || rx_hist !== 16'hA55A) begin
      errors++; $display("FAIL b2b_rx: got pulses=%0d bytes=%h expected 2/a55a",
        rx_cnt - r0, rx_hist);
    end
    checks++;
    if (m !== 16'h1234) begin
      errors++; $display("FAIL b2b_miso: got %h expected 1234", m);
    end
    checks++;
    if (ur_cnt != u0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_state: got ur=%0d ready=%b expected 0/1",
        ur_cnt - u0, tx_ready);
    end
  endtask

  task automatic test_underrun();
    logic [15:0] m;
    int u0;
    u0 = ur_cnt;
    cs_low();
    xfer(16'h0000, 8, m);
    end_frame();
    checks++;
    if (ur_cnt - u0 != 1) begin
      errors++; $display("FAIL underrun_pulse: got %0d expected 1", ur_cnt - u0);
    end
    checks++;
    if (m[7:0] !== 8'hFF || rx_data !== 8'h00) begin
      errors++; $display("FAIL underrun_data: got miso=%h rx=%h expected ff/00",
        m[7:0], rx_data);
    end
  endtask

  task automatic test_frame_err();
    logic [15:0] m;
    int r0, f0;
    r0 = rx_cnt; f0 = fe_cnt;
    cs_low();
    xfer(16'h0005, 3, m);
    end_frame();
    checks++;
    if (fe_cnt - f0 != 1 || rx_cnt != r0 || rx_data !== 8'h00) begin
      errors++; $display("FAIL frame_err: got fe=%0d rx=%0d data=%h expected 1/0/00",
        fe_cnt - f0, rx_cnt - r0, rx_data);
    end
    cs_low();
    xfer(16'h00C3, 8, m);
    end_frame();
    checks++;
    if (rx_data !== 8'hC3 || rx_cnt - r0 != 1 || fe_cnt - f0 != 1) begin
      errors++; $display("FAIL frame_err_next: got %h rx=%0d fe=%0d expected c3/1/1",
        rx_data, rx_cnt - r0, fe_cnt - f0);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] m;
    int r0, f0;
    cs_low();
    host_write(8'h66);
    xfer(16'h000F, 4, m);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(1);
    checks++;
    if ({miso, miso_oe, busy, rx_valid, frame_err, tx_underrun} !== 6'b0 ||
        rx_data !== 8'h00 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_outs: got %b rx=%h ready=%b expected 000000/00/1",
        {miso, miso_oe, busy, rx_valid, frame_err, tx_underrun}, rx_data, tx_ready);
    end
    r0 = rx_cnt; f0 = fe_cnt;
    xfer(16'h000F, 4, m);
    checks++;
    if (busy !== 1'b0 || miso_oe !== 1'b0) begin
      errors++; $display("FAIL midreset_ignore: got busy=%b oe=%b expected 0/0", busy, miso_oe);
    end
    end_frame();
    checks++;
    if (rx_cnt != r0 || fe_cnt != f0) begin
      errors++; $display("FAIL midreset_tail: got rx=%0d fe=%0d expected 0/0",
        rx_cnt - r0, fe_cnt - f0);
    end
    cs_low();
    xfer(16'h0081, 8, m);
    end_frame();
    checks++;
    if (rx_data !== 8'h81 || rx_cnt - r0 != 1) begin
      errors++; $display("FAIL midreset_next: got %h pulses=%0d expected 81/1",
        rx_data, rx_cnt - r0);
    end
  endtask

  task automatic test_write_at_load();
    logic [15:0] m;
    int u0;
    u0 = ur_cnt;
    host_write(8'h11);
    // cs falls here; the load point lands on the posedge between wait 2 and 3.
    cs = 1'b0;
    wait_clk(2);
    tx_data  = 8'h22;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL wload_ready: got %b expected 1", tx_ready);
    end
    wait_clk(5);
    xfer(16'h0000, 8, m);
    end_frame();
    checks++;
    if (m[7:0] !== 8'h11 || tx_ready !== 1'b1 || ur_cnt != u0) begin
      errors++; $display("FAIL wload_frame: got miso=%h ready=%b ur=%0d expected 11/1/0",
        m[7:0], tx_ready, ur_cnt - u0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_frame_err();
    test_mid_reset();
    test_write_at_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) that forms the far end of the link driven by our `spi_master`.
- `sclk`, `cs` and `mosi` are asynchronous to `clk`. The block oversamples them through synchronizers, then shifts received bits into `rx_data` and drives `miso` from a one-deep transmit buffer.
- It sits at the peripheral side of the bus, or in benches as the loopback partner for `spi_master`. Its host side is a simple valid/ready load port plus pulse status outputs.

Parameters:
- DATA_WIDTH, 8, bits per frame.
- SYNC_STAGES, 2, flip-flop stages on each of `sclk`, `cs` and `mosi` (minimum 2).
- IDLE_FILL, 8'hFF, byte shifted out when no transmit byte is pending (width DATA_WIDTH).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  DATA_WIDTH  byte to be returned to the master.
- tx_valid  in  1  host offers `tx_data`.
- tx_ready  out  1  transmit buffer empty; write accepted when `tx_valid & tx_ready`.
- rx_data  out  DATA_WIDTH  last complete byte received; held until the next completion.
- rx_valid  out  1  one-cycle pulse when `rx_data` updates.
- busy  out  1  synchronized `cs` is low (frame active).
- frame_err  out  1  one-cycle pulse when `cs` rises with a partial byte.
- tx_underrun  out  1  one-cycle pulse when IDLE_FILL is loaded because the buffer was empty.
- sclk  in  1  SPI clock from master.
- cs  in  1  chip select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  output enable for the `miso` pad driver; equals `busy`.

Behaviour:
- Reset applies on a `clk` edge with `reset`=1, including mid-frame. Resulting output values:
  - `miso`, `miso_oe`, `busy`, `rx_valid`, `frame_err`, `tx_underrun`: 0.
  - `rx_data`: 0.
  - `tx_ready`: 1.
  - Buffer emptied, bit counter 0, synchronizers reset to `cs`=1 and `sclk`=0.
  - After reset deasserts, a frame already in progress is ignored until `cs` is seen high, then low again.
- Synchronizers: SYNC_STAGES flip-flops per input. Edges are detected on the synchronized `sclk`/`cs` against a registered copy, giving 1-cycle edge pulses.
- Timing requirement on the master: `sclk` high and low times are each ≥ SYNC_STAGES+2 `clk` periods, i.e. `sclk` ≤ clk/8 with defaults.
- State IDLE (synchronized `cs`=1): `miso`=0, `miso_oe`=0, sclk edges ignored.
- IDLE→ACTIVE on the `cs` falling edge, in the same cycle:
  - Load point: the tx shift register loads the buffer if it is full (buffer is freed, so `tx_ready` goes 1 the next cycle); otherwise it loads IDLE_FILL and pulses `tx_underrun`.
  - `miso` = MSB of the loaded value, bit counter cleared.
- ACTIVE, `sclk` rising edge:
  - Shift the synchronized `mosi` into the rx shift register LSB; bit counter increments.
  - On the DATA_WIDTH-th rise: `rx_data` ← {rx_shift[DATA_WIDTH-2:0], mosi}; `rx_valid` pulses the next cycle; bit counter returns to 0; `reload` flag set.
- ACTIVE, `sclk` falling edge:
  - If `reload` is set: clear it and perform the load point (back-to-back frames while `cs` stays low).
  - Otherwise: shift the tx register left and drive the new MSB on `miso`.
- ACTIVE→IDLE on the `cs` rising edge:
  - If bit counter ≠ 0, pulse `frame_err` and discard the partial byte; no `rx_valid`.
  - The tx byte already loaded is consumed, not restored. Counter and `reload` are cleared.
- Simultaneous events:
  - A `cs` edge takes priority over an `sclk` edge in the same cycle.
  - A host write and a load point in the same cycle: the load uses the buffer contents before the write. The write is accepted only if `tx_ready` was 1 that cycle, and the written byte becomes pending for the next load point (no bypass).
- `tx_ready` = buffer empty.
- `rx_valid` has no backpressure. The host must capture `rx_data` before the next completion, which comes at least DATA_WIDTH `sclk` periods later.

Test Plan:
- Preload 0x3C, master model sends 0xA5 at clk/8 → `rx_data`=0xA5 with one `rx_valid` pulse; master captures 0x3C; `tx_ready` returns to 1 one cycle after the `cs` falling edge; no `frame_err`/`tx_underrun`.
- Preload 0x12, then write 0x34 after the first load while `cs` stays low for 16 `sclk`s carrying 0xA5, 0x5A → two `rx_valid` pulses (0xA5, then 0x5A); master receives 0x12, 0x34.
- Buffer empty at `cs` falling edge, master sends 0x00 → `tx_underrun` pulses once; master receives 0xFF; `rx_data`=0x00.
- `cs` raised after 3 `sclk` rises → `frame_err` pulse, no `rx_valid`, `rx_data` unchanged; next full frame of 0xC3 is received correctly.
- Assert `reset` after 4 bits of a frame → all outputs at reset values and `tx_ready`=1; the remaining bits of that frame are ignored; the next `cs`-low frame of 0x81 → `rx_data`=0x81.
- Host write coincident with the load point (buffer holds 0x11, write 0x22 with `tx_ready`=0) → write not accepted; frame sends 0x11; the buffer is empty afterwards.
